// File: rtl/reg_file_fwd.sv
// 32x32 register file with writeback write port, two forwarded ID read ports
// (EX > MEM > WB > storage), load-use stall detection and a raw debug port.
module reg_file_fwd (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  id_rsAddr,
  input  logic [4:0]  id_rtAddr,
  input  logic        id_rsUsed,
  input  logic        id_rtUsed,
  output logic [31:0] id_rsData,
  output logic [31:0] id_rtData,
  output logic        id_stall,
  input  logic        ex_regWriteEn,
  input  logic [4:0]  ex_regWriteAddr,
  input  logic [31:0] ex_regWriteData,
  input  logic        ex_memRead,
  input  logic        mem_regWriteEn,
  input  logic [4:0]  mem_regWriteAddr,
  input  logic [31:0] mem_regWriteData,
  input  logic        wb_regWriteEn,
  input  logic [4:0]  wb_regWriteAddr,
  input  logic [31:0] wb_regWriteData,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  // A load in EX has no data yet, so it is never a forwarding source.
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  addr,
    input logic [31:0] stored,
    input logic        ex_en,
    input logic [4:0]  ex_addr,
    input logic [31:0] ex_data,
    input logic        ex_ld,
    input logic        mem_en,
    input logic [4:0]  mem_addr,
    input logic [31:0] mem_data,
    input logic        wb_en,
    input logic [4:0]  wb_addr,
    input logic [31:0] wb_data
  );
    if (addr == 5'd0) begin
      fwd_sel = 32'd0;
    end else if (ex_en && !ex_ld && ex_addr == addr) begin
      fwd_sel = ex_data;
    end else if (mem_en && mem_addr == addr) begin
      fwd_sel = mem_data;
    end else if (wb_en && wb_addr == addr) begin
      fwd_sel = wb_data;
    end else begin
      fwd_sel = stored;
    end
  endfunction

  // Next storage state: synchronous clear in reset, else the WB write (r0 never written).
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (!rstn) begin
      for (int i = 0; i < 32; i++) begin
        regs_d[i] = 32'd0;
      end
    end else if (wb_regWriteEn && wb_regWriteAddr != 5'd0) begin
      regs_d[wb_regWriteAddr] = wb_regWriteData;
    end
  end

  // Storage register.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      regs_q[i] <= regs_d[i];
    end
  end

  // Forwarded reads, load-use stall and debug read; all masked to zero during reset.
  always_comb begin
    id_rsData = 32'd0;
    id_rtData = 32'd0;
    id_stall  = 1'b0;
    dbg_data  = 32'd0;
    if (rstn) begin
      id_rsData = fwd_sel(id_rsAddr, regs_q[id_rsAddr],
                          ex_regWriteEn, ex_regWriteAddr, ex_regWriteData, ex_memRead,
                          mem_regWriteEn, mem_regWriteAddr, mem_regWriteData,
                          wb_regWriteEn, wb_regWriteAddr, wb_regWriteData);
      id_rtData = fwd_sel(id_rtAddr, regs_q[id_rtAddr],
                          ex_regWriteEn, ex_regWriteAddr, ex_regWriteData, ex_memRead,
                          mem_regWriteEn, mem_regWriteAddr, mem_regWriteData,
                          wb_regWriteEn, wb_regWriteAddr, wb_regWriteData);
      id_stall  = ex_memRead && ex_regWriteEn && (ex_regWriteAddr != 5'd0) &&
                  ((id_rsUsed && id_rsAddr == ex_regWriteAddr) ||
                   (id_rtUsed && id_rtAddr == ex_regWriteAddr));
      dbg_data  = (dbg_addr == 5'd0) ? 32'd0 : regs_q[dbg_addr];
    end
  end

endmodule

// File: tb/tb_reg_file_fwd.sv
// Randomised + directed bench for reg_file_fwd: stimulus pushes expected
// outputs into a queue, a negedge monitor pops and compares.
module tb_reg_file_fwd;

  logic        clk = 1'b0;
  logic        rstn;
  logic [4:0]  id_rsAddr, id_rtAddr;
  logic        id_rsUsed, id_rtUsed;
  logic [31:0] id_rsData, id_rtData;
  logic        id_stall;
  logic        ex_regWriteEn, ex_memRead;
  logic [4:0]  ex_regWriteAddr;
  logic [31:0] ex_regWriteData;
  logic        mem_regWriteEn;
  logic [4:0]  mem_regWriteAddr;
  logic [31:0] mem_regWriteData;
  logic        wb_regWriteEn;
  logic [4:0]  wb_regWriteAddr;
  logic [31:0] wb_regWriteData;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  always #5 clk = ~clk;

  reg_file_fwd dut (
    .clk              (clk),
    .rstn             (rstn),
    .id_rsAddr        (id_rsAddr),
    .id_rtAddr        (id_rtAddr),
    .id_rsUsed        (id_rsUsed),
    .id_rtUsed        (id_rtUsed),
    .id_rsData        (id_rsData),
    .id_rtData        (id_rtData),
    .id_stall         (id_stall),
    .ex_regWriteEn    (ex_regWriteEn),
    .ex_regWriteAddr  (ex_regWriteAddr),
    .ex_regWriteData  (ex_regWriteData),
    .ex_memRead       (ex_memRead),
    .mem_regWriteEn   (mem_regWriteEn),
    .mem_regWriteAddr (mem_regWriteAddr),
    .mem_regWriteData (mem_regWriteData),
    .wb_regWriteEn    (wb_regWriteEn),
    .wb_regWriteAddr  (wb_regWriteAddr),
    .wb_regWriteData  (wb_regWriteData),
    .dbg_addr         (dbg_addr),
    .dbg_data         (dbg_data)
  );

  typedef struct {
    logic        rstn;
    logic [4:0]  rs, rt;
    logic        rsu, rtu;
    logic        ex_en, ex_ld;
    logic [4:0]  ex_addr;
    logic [31:0] ex_data;
    logic        mem_en;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  dbg;
  } txn_t;

  typedef struct {
    int          step;
    logic [31:0] rs_data, rt_data, dbg_data;
    logic        stall;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [32];
  txn_t        prev;
  int          total = 0;
  int          bad = 0;
  int          step = 0;

  function automatic txn_t idle();
    txn_t t;
    t = '{rstn: 1'b1, rs: 5'd0, rt: 5'd0, rsu: 1'b0, rtu: 1'b0, ex_en: 1'b0, ex_ld: 1'b0,
          ex_addr: 5'd0, ex_data: 32'd0, mem_en: 1'b0, mem_addr: 5'd0, mem_data: 32'd0,
          wb_en: 1'b0, wb_addr: 5'd0, wb_data: 32'd0, dbg: 5'd0};
    return t;
  endfunction

  // Reference read: walk the writers youngest-first, first live match wins.
  function automatic logic [31:0] ref_read(input txn_t t, input logic [4:0] a);
    logic        en  [3];
    logic [4:0]  adr [3];
    logic [31:0] dat [3];
    if (!t.rstn || a == 5'd0) return 32'd0;
    en[0] = t.ex_en && !t.ex_ld; adr[0] = t.ex_addr;  dat[0] = t.ex_data;
    en[1] = t.mem_en;            adr[1] = t.mem_addr; dat[1] = t.mem_data;
    en[2] = t.wb_en;             adr[2] = t.wb_addr;  dat[2] = t.wb_data;
    for (int k = 0; k < 3; k++) begin
      if (en[k] && adr[k] == a) return dat[k];
    end
    return model[a];
  endfunction

  task automatic drive(input txn_t t);
    exp_t e;
    @(posedge clk);
    // Commit last cycle's effect on architectural state.
    if (!prev.rstn) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
    end else if (prev.wb_en && prev.wb_addr != 5'd0) begin
      model[prev.wb_addr] = prev.wb_data;
    end
    #1;
    rstn             = t.rstn;
    id_rsAddr        = t.rs;       id_rtAddr        = t.rt;
    id_rsUsed        = t.rsu;      id_rtUsed        = t.rtu;
    ex_regWriteEn    = t.ex_en;    ex_regWriteAddr  = t.ex_addr;
    ex_regWriteData  = t.ex_data;  ex_memRead       = t.ex_ld;
    mem_regWriteEn   = t.mem_en;   mem_regWriteAddr = t.mem_addr;
    mem_regWriteData = t.mem_data;
    wb_regWriteEn    = t.wb_en;    wb_regWriteAddr  = t.wb_addr;
    wb_regWriteData  = t.wb_data;  dbg_addr         = t.dbg;
    e.step     = step;
    e.rs_data  = ref_read(t, t.rs);
    e.rt_data  = ref_read(t, t.rt);
    e.dbg_data = (!t.rstn || t.dbg == 5'd0) ? 32'd0 : model[t.dbg];
    e.stall    = t.rstn && t.ex_ld && t.ex_en && t.ex_addr != 5'd0 &&
                 ((t.rsu && t.rs == t.ex_addr) || (t.rtu && t.rt == t.ex_addr));
    exp_q.push_back(e);
    prev = t;
    step++;
  endtask

  task automatic check32(input string nm, input int s, input logic [31:0] act,
                         input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s step%0d actual=%h required=%h", nm, s, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so each cycle's response is sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check32("rsData", e.step, id_rsData, e.rs_data);
        check32("rtData", e.step, id_rtData, e.rt_data);
        check32("dbgData", e.step, dbg_data, e.dbg_data);
        check32("stall", e.step, {31'd0, id_stall}, {31'd0, e.stall});
      end
    end
  end

  initial begin
    txn_t t;
    int   wait_cyc;
    prev = idle();
    prev.rstn = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;

    // Reset, then basic write with write-through and stored readback.
    t = idle(); t.rstn = 1'b0; drive(t);
    t = idle(); t.wb_en = 1'b1; t.wb_addr = 5'd5; t.wb_data = 32'h12345678;
    t.rs = 5'd5; t.dbg = 5'd5; drive(t);
    t = idle(); t.rs = 5'd5; t.dbg = 5'd5; drive(t);

    // Register zero is immune to writes and forwarding.
    t = idle(); t.wb_en = 1'b1; t.wb_addr = 5'd0; t.wb_data = 32'hFFFFFFFF;
    t.ex_en = 1'b1; t.ex_addr = 5'd0; t.ex_data = 32'hAAAA; drive(t);
    t = idle(); t.dbg = 5'd0; drive(t);

    // Forward priority on r7.
    t = idle(); t.wb_en = 1'b1; t.wb_addr = 5'd7; t.wb_data = 32'd1; drive(t);
    t = idle(); t.rs = 5'd7; t.dbg = 5'd7;
    t.wb_en = 1'b1;  t.wb_addr = 5'd7;  t.wb_data = 32'd2;
    t.mem_en = 1'b1; t.mem_addr = 5'd7; t.mem_data = 32'd3;
    t.ex_en = 1'b1;  t.ex_addr = 5'd7;  t.ex_data = 32'd4; drive(t);
    t.ex_en = 1'b0; drive(t);
    t.mem_en = 1'b0; drive(t);
    t = idle(); t.rs = 5'd7; t.rt = 5'd7; t.dbg = 5'd7; drive(t);

    // Load-use stall and release.
    t = idle(); t.ex_en = 1'b1; t.ex_ld = 1'b1; t.ex_addr = 5'd9; t.ex_data = 32'hBAD;
    t.rt = 5'd9; t.rtu = 1'b1; drive(t);
    t.rtu = 1'b0; drive(t);
    t = idle(); t.mem_en = 1'b1; t.mem_addr = 5'd9; t.mem_data = 32'hCAFE;
    t.rt = 5'd9; t.rtu = 1'b1; drive(t);

    // Disabled MEM source must not match.
    t = idle(); t.wb_en = 1'b1; t.wb_addr = 5'd3; t.wb_data = 32'h11; drive(t);
    t = idle(); t.mem_addr = 5'd3; t.mem_data = 32'hDEAD; t.rs = 5'd3; drive(t);

    // Reset mid-operation drops the WB write and masks the stall.
    t = idle(); t.wb_en = 1'b1; t.wb_addr = 5'd4; t.wb_data = 32'h99; drive(t);
    t = idle(); t.rstn = 1'b0; t.wb_en = 1'b1; t.wb_addr = 5'd4; t.wb_data = 32'h55;
    t.ex_en = 1'b1; t.ex_ld = 1'b1; t.ex_addr = 5'd4; t.rs = 5'd4; t.rsu = 1'b1;
    t.dbg = 5'd4; drive(t);
    t = idle(); t.rs = 5'd4; t.dbg = 5'd4; drive(t);

    // Random traffic on a narrow address range to force collisions.
    for (int n = 0; n < 400; n++) begin
      t.rstn     = ($urandom_range(0, 59) != 0);
      t.rs       = 5'($urandom_range(0, 7));
      t.rt       = 5'($urandom_range(0, 7));
      t.rsu      = 1'($urandom);
      t.rtu      = 1'($urandom);
      t.ex_en    = 1'($urandom);
      t.ex_ld    = ($urandom_range(0, 3) == 0);
      t.ex_addr  = 5'($urandom_range(0, 7));
      t.ex_data  = $urandom;
      t.mem_en   = 1'($urandom);
      t.mem_addr = 5'($urandom_range(0, 7));
      t.mem_data = $urandom;
      t.wb_en    = 1'($urandom);
      t.wb_addr  = 5'($urandom_range(0, 7));
      t.wb_data  = $urandom;
      t.dbg      = 5'($urandom_range(0, 7));
      drive(t);
    end

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
